// File: rtl/freqdiv_bank_pkg.sv
// Shared definitions for the programmable clock-enable divider bank.
//   chan_state_e : per-channel IDLE/RUN state
//   MIN_DIV      : smallest divisor a channel will run with
//   chw_of()     : channel-select width, never less than 1 bit
package freqdiv_bank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned chw_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/freqdiv_chan.sv
// One programmable divider channel: IDLE/RUN FSM, period counter, shadow divisor.
//   clk, reset     : clock, synchronous active-low reset
//   en             : run enable
//   sync           : restart at count 0 when running
//   ld, ld_div     : shadow divisor write strobe and value
//   clk_out        : divided output, high for ceil(div/2) cycles of each period
//   tick           : high on the first cycle of each period
//   active         : channel is in RUN
module freqdiv_chan
  import freqdiv_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_div,
  output logic             clk_out,
  output logic             tick,
  output logic             active
);

  chan_state_e      state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] load_div;
  logic             load_ok;
  logic [WIDTH:0]   half;
  logic [WIDTH-1:0] cnt_inc;
  logic             wrap;

  always_comb begin
    // A same-cycle write is visible to the load decision; otherwise the shadow is used.
    load_div  = ld ? ld_div : shadow_q;
    load_ok   = (load_div >= WIDTH'(MIN_DIV));
    half      = ({1'b0, cur_div_q} + (WIDTH + 1)'(1)) >> 1;
    cnt_inc   = cnt_q + WIDTH'(1);
    wrap      = (cnt_q == cur_div_q - WIDTH'(1));

    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    shadow_d  = ld ? ld_div : shadow_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en && load_ok) begin
          state_d   = ST_RUN;
          cur_div_d = load_div;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sync || wrap) begin
          // sync landing on a natural wrap collapses into this single restart
          cnt_d = '0;
          if (load_ok) begin
            cur_div_d = load_div;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d     = cnt_inc;
          clk_out_d = ({1'b0, cnt_inc} < half);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_div_q <= WIDTH'(DEFAULT_DIV);
      shadow_q  <= WIDTH'(DEFAULT_DIV);
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      shadow_q  <= shadow_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign active  = (state_q == ST_RUN);

endmodule

// File: rtl/freqdiv_bank.sv
// Bank of NCH independent programmable clock-enable dividers.
//   clk, reset      : clock, synchronous active-low reset
//   en[NCH]         : per-channel run enable
//   sync            : phase-align all running channels to count 0
//   wr_en/wr_ch/wr_div : shadow divisor write; wr_ch >= NCH is ignored
//   clk_out[NCH]    : divided outputs
//   tick[NCH]       : period-start pulses
//   active[NCH]     : channel running
module freqdiv_bank
  import freqdiv_bank_pkg::*;
#(
  parameter  int unsigned NCH         = 4,
  parameter  int unsigned WIDTH       = 8,
  parameter  int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CHW         = chw_of(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   active
);

  logic [NCH-1:0] ld;

  always_comb begin
    ld = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ld[i] = wr_en && (32'(wr_ch) == i);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    freqdiv_chan #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en     (en[g]),
      .sync   (sync),
      .ld     (ld[g]),
      .ld_div (wr_div),
      .clk_out(clk_out[g]),
      .tick   (tick[g]),
      .active (active[g])
    );
  end

endmodule
